axi_rd_arbiter: RTL and testbench

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

---
 rtl/axi_rd_arbiter.sv | 118 +++++++++++
 tb/tb_axi_rd_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-master (IFU/LSU) single-outstanding AXI read arbiter in front of one SRAM port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default build gives ties to LSU.
module axi_rd_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ifu_AR_ADDR,
  input  logic              ifu_AR_VALID,
  output logic              ifu_AR_READY,
  output logic [DATA_W-1:0] ifu_R_DATA,
  output logic              ifu_R_VALID,
  input  logic              ifu_R_READY,
  input  logic [ADDR_W-1:0] lsu_AR_ADDR,
  input  logic              lsu_AR_VALID,
  output logic              lsu_AR_READY,
  output logic [DATA_W-1:0] lsu_R_DATA,
  output logic              lsu_R_VALID,
  input  logic              lsu_R_READY,
  output logic [ADDR_W-1:0] axi_AR_ADDR,
  output logic              axi_AR_VALID,
  input  logic              axi_AR_READY,
  input  logic [DATA_W-1:0] axi_R_DATA,
  input  logic              axi_R_VALID,
  output logic              axi_R_READY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t            state, state_next;
  logic              grant_lsu, grant_lsu_next;
  logic [ADDR_W-1:0] ar_addr, ar_addr_next;
  logic              ar_valid, ar_valid_next;
  logic              any_req;
  logic              pick_lsu;
  logic              r_fire;

  assign any_req = ifu_AR_VALID | lsu_AR_VALID;

`ifdef ARB_ROUND_ROBIN_EN
  // last_lsu starts at 1 so the very first tie goes to IFU
  logic last_lsu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_lsu <= 1'b1;
    else if (state == IDLE && any_req)
      last_lsu <= pick_lsu;
  end

  assign pick_lsu = lsu_AR_VALID & (~ifu_AR_VALID | ~last_lsu);
`else
  assign pick_lsu = lsu_AR_VALID;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_lsu <= 1'b0;
      ar_addr   <= '0;
      ar_valid  <= 1'b0;
    end else begin
      state     <= state_next;
      grant_lsu <= grant_lsu_next;
      ar_addr   <= ar_addr_next;
      ar_valid  <= ar_valid_next;
    end
  end

  assign axi_AR_ADDR  = ar_addr;
  assign axi_AR_VALID = ar_valid;
  assign ifu_R_DATA   = axi_R_DATA;
  assign lsu_R_DATA   = axi_R_DATA;

  // Master-facing handshakes are gated by state, so reset forces them low at once
  always_comb begin
    ifu_AR_READY   = 1'b0;
    lsu_AR_READY   = 1'b0;
    ifu_R_VALID    = 1'b0;
    lsu_R_VALID    = 1'b0;
    axi_R_READY    = 1'b0;
    r_fire         = 1'b0;
    state_next     = state;
    grant_lsu_next = grant_lsu;
    ar_addr_next   = ar_addr;
    ar_valid_next  = ar_valid;

    case (state)
      IDLE: begin
        if (any_req) begin
          grant_lsu_next = pick_lsu;
          ar_addr_next   = pick_lsu ? lsu_AR_ADDR : ifu_AR_ADDR;
          ar_valid_next  = 1'b1;
          state_next     = ADDR;
        end
      end
      ADDR: begin
        ifu_AR_READY = axi_AR_READY & ~grant_lsu;
        lsu_AR_READY = axi_AR_READY &  grant_lsu;
        if (axi_AR_READY) begin
          ar_valid_next = 1'b0;
          state_next    = DATA;
        end
      end
      DATA: begin
        ifu_R_VALID = axi_R_VALID & ~grant_lsu;
        lsu_R_VALID = axi_R_VALID &  grant_lsu;
        axi_R_READY = grant_lsu ? lsu_R_READY : ifu_R_READY;
        r_fire      = axi_R_VALID & axi_R_READY;
        if (r_fire)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter; tie-breaking expectations follow ARB_ROUND_ROBIN_EN.
module tb_axi_rd_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] ifu_AR_ADDR, lsu_AR_ADDR, axi_AR_ADDR;
  logic              ifu_AR_VALID, ifu_AR_READY, ifu_R_VALID, ifu_R_READY;
  logic              lsu_AR_VALID, lsu_AR_READY, lsu_R_VALID, lsu_R_READY;
  logic [DATA_W-1:0] ifu_R_DATA, lsu_R_DATA, axi_R_DATA;
  logic              axi_AR_VALID, axi_AR_READY, axi_R_VALID, axi_R_READY;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: which master was granted most recently
  bit model_last_lsu;

  // Observations gathered by run_txn
  logic [ADDR_W-1:0] obs_addr;
  bit                obs_av_first, obs_av_after, obs_addr_stable;
  bit                obs_rready_stall, obs_rready_final;
  int                obs_av_cycles, obs_ifu_arr, obs_lsu_arr, obs_ifu_rv, obs_lsu_rv;
  logic [DATA_W-1:0] obs_ifu_data, obs_lsu_data;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_AR_ADDR(ifu_AR_ADDR), .ifu_AR_VALID(ifu_AR_VALID), .ifu_AR_READY(ifu_AR_READY),
    .ifu_R_DATA(ifu_R_DATA), .ifu_R_VALID(ifu_R_VALID), .ifu_R_READY(ifu_R_READY),
    .lsu_AR_ADDR(lsu_AR_ADDR), .lsu_AR_VALID(lsu_AR_VALID), .lsu_AR_READY(lsu_AR_READY),
    .lsu_R_DATA(lsu_R_DATA), .lsu_R_VALID(lsu_R_VALID), .lsu_R_READY(lsu_R_READY),
    .axi_AR_ADDR(axi_AR_ADDR), .axi_AR_VALID(axi_AR_VALID), .axi_AR_READY(axi_AR_READY),
    .axi_R_DATA(axi_R_DATA), .axi_R_VALID(axi_R_VALID), .axi_R_READY(axi_R_READY)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tie rule: single requester wins; ties to LSU, or to the other master under round-robin
  task automatic predict(input bit ifu_req, input bit lsu_req, output bit win_lsu);
    if (!lsu_req)
      win_lsu = 1'b0;
    else if (!ifu_req)
      win_lsu = 1'b1;
    else begin
`ifdef ARB_ROUND_ROBIN_EN
      win_lsu = !model_last_lsu;
`else
      win_lsu = 1'b1;
`endif
    end
    model_last_lsu = win_lsu;
  endtask

  task automatic clear_inputs();
    ifu_AR_VALID = 1'b0; lsu_AR_VALID = 1'b0;
    ifu_AR_ADDR  = '0;   lsu_AR_ADDR  = '0;
    ifu_R_READY  = 1'b0; lsu_R_READY  = 1'b0;
    axi_AR_READY = 1'b0; axi_R_VALID  = 1'b0;
    axi_R_DATA   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    model_last_lsu = 1'b1;
  endtask

  // One full read: request, optional AR stall, optional R stall by the granted master
  task automatic run_txn(input bit ifu_req, input bit lsu_req,
                         input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] la,
                         input int ar_dly, input int r_stall,
                         input logic [DATA_W-1:0] data, input bit win_lsu);
    ifu_AR_VALID = ifu_req; ifu_AR_ADDR = ia;
    lsu_AR_VALID = lsu_req; lsu_AR_ADDR = la;
    obs_av_cycles = 0; obs_ifu_arr = 0; obs_lsu_arr = 0; obs_ifu_rv = 0; obs_lsu_rv = 0;
    obs_addr_stable = 1'b1; obs_rready_stall = 1'b0;
    step();
    obs_av_first = axi_AR_VALID;
    obs_addr     = axi_AR_ADDR;
    for (int i = 0; i <= ar_dly; i++) begin
      if (i == ar_dly) begin
        axi_AR_READY = 1'b1;
        #1;
      end
      obs_av_cycles += int'(axi_AR_VALID);
      if (axi_AR_ADDR !== obs_addr) obs_addr_stable = 1'b0;
      obs_ifu_arr += int'(ifu_AR_READY);
      obs_lsu_arr += int'(lsu_AR_READY);
      step();
    end
    axi_AR_READY = 1'b0;
    if (win_lsu) lsu_AR_VALID = 1'b0; else ifu_AR_VALID = 1'b0;
    #1;
    obs_av_after = axi_AR_VALID;
    axi_R_VALID = 1'b1;
    axi_R_DATA  = data;
    for (int i = 0; i <= r_stall; i++) begin
      ifu_R_READY = (i == r_stall) ? !win_lsu : win_lsu;
      lsu_R_READY = (i == r_stall) ?  win_lsu : !win_lsu;
      #1;
      obs_ifu_rv  += int'(ifu_R_VALID);
      obs_lsu_rv  += int'(lsu_R_VALID);
      obs_ifu_arr += int'(ifu_AR_READY);
      obs_lsu_arr += int'(lsu_AR_READY);
      if (i < r_stall) begin
        obs_rready_stall |= axi_R_READY;
      end else begin
        obs_rready_final = axi_R_READY;
        obs_ifu_data     = ifu_R_DATA;
        obs_lsu_data     = lsu_R_DATA;
      end
      step();
    end
    axi_R_VALID = 1'b0;
    ifu_R_READY = 1'b0;
    lsu_R_READY = 1'b0;
    axi_R_DATA  = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifu_AR_VALID = 1'b1; lsu_AR_VALID = 1'b1;
    ifu_AR_ADDR = 64'h1234; lsu_AR_ADDR = 64'h5678;
    ifu_R_READY = 1'b1; lsu_R_READY = 1'b1;
    axi_AR_READY = 1'b1; axi_R_VALID = 1'b1; axi_R_DATA = 64'hdead;
    #3;
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if ({ifu_AR_READY, lsu_AR_READY, ifu_R_VALID, lsu_R_VALID, axi_AR_VALID, axi_R_READY} !== 6'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                 {ifu_AR_READY, lsu_AR_READY, ifu_R_VALID, lsu_R_VALID, axi_AR_VALID, axi_R_READY});
      end
      tests_run++;
      if (axi_AR_ADDR !== '0) begin
        tests_failed++;
        $display("[TB] FAIL reset_addr: got %h expected 0", axi_AR_ADDR);
      end
      step();
    end
    clear_inputs();
    rst_n = 1'b1;
    model_last_lsu = 1'b1;
  endtask

  task automatic test_ifu_alone();
    bit w;
    predict(1'b1, 1'b0, w);
    run_txn(1'b1, 1'b0, 64'h8000_0000, 64'h0, 0, 0, 64'h13, w);
    tests_run++;
    if (obs_av_first !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ifu_av_latency: got %b expected 1", obs_av_first);
    end
    tests_run++;
    if (obs_addr !== 64'h8000_0000) begin
      tests_failed++;
      $display("[TB] FAIL ifu_addr: got %h expected 80000000", obs_addr);
    end
    tests_run++;
    if (obs_ifu_rv !== 1 || obs_lsu_rv !== 0) begin
      tests_failed++;
      $display("[TB] FAIL ifu_rvalid: got ifu=%0d lsu=%0d expected ifu=1 lsu=0", obs_ifu_rv, obs_lsu_rv);
    end
    tests_run++;
    if (obs_ifu_data !== 64'h13 || obs_lsu_data !== 64'h13) begin
      tests_failed++;
      $display("[TB] FAIL ifu_data: got ifu=%h lsu=%h expected 13", obs_ifu_data, obs_lsu_data);
    end
    tests_run++;
    if (obs_av_after !== 1'b0 || obs_rready_final !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ifu_handshake: got av_after=%b rready=%b expected 0/1", obs_av_after, obs_rready_final);
    end
  endtask

  task automatic test_tie();
    bit w1, w2;
    logic [ADDR_W-1:0] ia, la;
    ia = 64'h8000_0004;
    la = 64'h8000_1000;
    do_reset();
    predict(1'b1, 1'b1, w1);
    run_txn(1'b1, 1'b1, ia, la, 0, 0, 64'hA1, w1);
    tests_run++;
    if ((w1 ? obs_lsu_arr : obs_ifu_arr) !== 1 || (w1 ? obs_ifu_arr : obs_lsu_arr) !== 0) begin
      tests_failed++;
      $display("[TB] FAIL tie_first_grant: got ifu_arr=%0d lsu_arr=%0d expected winner lsu=%b",
               obs_ifu_arr, obs_lsu_arr, w1);
    end
    tests_run++;
    if (obs_addr !== (w1 ? la : ia)) begin
      tests_failed++;
      $display("[TB] FAIL tie_first_addr: got %h expected %h", obs_addr, (w1 ? la : ia));
    end
    predict(w1, !w1, w2);
    run_txn(w1, !w1, ia, la, 0, 0, 64'hB2, w2);
    tests_run++;
    if (obs_addr !== (w2 ? la : ia) || (w2 ? obs_lsu_arr : obs_ifu_arr) !== 1) begin
      tests_failed++;
      $display("[TB] FAIL tie_second: got addr=%h expected %h", obs_addr, (w2 ? la : ia));
    end
    tests_run++;
    if ((w2 ? obs_lsu_data : obs_ifu_data) !== 64'hB2) begin
      tests_failed++;
      $display("[TB] FAIL tie_second_data: got %h expected b2", (w2 ? obs_lsu_data : obs_ifu_data));
    end
  endtask

  task automatic test_ar_delay();
    bit w;
    predict(1'b0, 1'b1, w);
    run_txn(1'b0, 1'b1, 64'h0, 64'h8000_2000, 3, 0, 64'h77, w);
    tests_run++;
    if (obs_av_cycles !== 4 || obs_addr_stable !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ar_delay_hold: got cycles=%0d stable=%b expected 4/1", obs_av_cycles, obs_addr_stable);
    end
    tests_run++;
    if (obs_lsu_arr !== 1 || obs_ifu_arr !== 0) begin
      tests_failed++;
      $display("[TB] FAIL ar_delay_pulse: got lsu=%0d ifu=%0d expected 1/0", obs_lsu_arr, obs_ifu_arr);
    end
  endtask

  task automatic test_r_stall();
    bit w;
    predict(1'b1, 1'b0, w);
    run_txn(1'b1, 1'b0, 64'h8000_0008, 64'h0, 0, 2, 64'hCAFE, w);
    tests_run++;
    if (obs_rready_stall !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL r_stall_ready: got %b expected 0", obs_rready_stall);
    end
    tests_run++;
    if (obs_ifu_rv !== 3 || obs_lsu_rv !== 0 || obs_ifu_arr !== 1 || obs_lsu_arr !== 0) begin
      tests_failed++;
      $display("[TB] FAIL r_stall_grant: got ifu_rv=%0d lsu_rv=%0d ifu_arr=%0d lsu_arr=%0d expected 3/0/1/0",
               obs_ifu_rv, obs_lsu_rv, obs_ifu_arr, obs_lsu_arr);
    end
    tests_run++;
    if (obs_rready_final !== 1'b1 || obs_ifu_data !== 64'hCAFE) begin
      tests_failed++;
      $display("[TB] FAIL r_stall_done: got rready=%b data=%h expected 1/cafe", obs_rready_final, obs_ifu_data);
    end
  endtask

  task automatic test_reset_mid_data();
    bit w;
    ifu_AR_VALID = 1'b1; ifu_AR_ADDR = 64'h8000_0010;
    step();
    axi_AR_READY = 1'b1;
    step();
    axi_AR_READY = 1'b0; ifu_AR_VALID = 1'b0;
    axi_R_VALID = 1'b1; ifu_R_READY = 1'b0;
    #1;
    tests_run++;
    if (ifu_R_VALID !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_data_entry: got %b expected 1", ifu_R_VALID);
    end
    ifu_R_READY = 1'b1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({ifu_AR_READY, lsu_AR_READY, ifu_R_VALID, lsu_R_VALID, axi_AR_VALID, axi_R_READY} !== 6'b0
        || axi_AR_ADDR !== '0) begin
      tests_failed++;
      $display("[TB] FAIL mid_data_reset: got ctrl=%b addr=%h expected 0/0",
               {ifu_AR_READY, lsu_AR_READY, ifu_R_VALID, lsu_R_VALID, axi_AR_VALID, axi_R_READY}, axi_AR_ADDR);
    end
    do_reset();
    predict(1'b0, 1'b1, w);
    run_txn(1'b0, 1'b1, 64'h0, 64'h8000_3000, 1, 0, 64'h55, w);
    tests_run++;
    if (obs_addr !== 64'h8000_3000 || obs_lsu_arr !== 1 || obs_lsu_data !== 64'h55 || obs_ifu_rv !== 0) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_txn: got addr=%h arr=%0d data=%h expected 80003000/1/55",
               obs_addr, obs_lsu_arr, obs_lsu_data);
    end
  endtask

  task automatic test_back_to_back();
    bit w;
    logic [ADDR_W-1:0] ia, la;
    logic [DATA_W-1:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ia = {$urandom, $urandom}; la = {$urandom, $urandom}; d = {$urandom, $urandom};
      predict(1'b1, 1'b1, w);
      run_txn(1'b1, 1'b1, ia, la, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), d, w);
      tests_run++;
      if ((w ? obs_lsu_arr : obs_ifu_arr) !== 1 || (w ? obs_ifu_arr : obs_lsu_arr) !== 0
          || obs_addr !== (w ? la : ia)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_grant_%0d: got ifu_arr=%0d lsu_arr=%0d addr=%h expected lsu=%b addr=%h",
                 i, obs_ifu_arr, obs_lsu_arr, obs_addr, w, (w ? la : ia));
      end
      tests_run++;
      if ((w ? obs_lsu_data : obs_ifu_data) !== d || (w ? obs_ifu_rv : obs_lsu_rv) !== 0) begin
        tests_failed++;
        $display("[TB] FAIL b2b_data_%0d: got %h expected %h", i, (w ? obs_lsu_data : obs_ifu_data), d);
      end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_random();
    bit w, ir, lr, pend_i, pend_l;
    logic [ADDR_W-1:0] ia, la;
    logic [DATA_W-1:0] d;
    pend_i = 1'b0; pend_l = 1'b0;
    ia = '0; la = '0;
    for (int i = 0; i < 16; i++) begin
      if (i >= 12 && !pend_i && !pend_l) break;
      ir = pend_i ? 1'b1 : (i < 12 ? 1'($urandom) : 1'b0);
      lr = pend_l ? 1'b1 : (i < 12 ? 1'($urandom) : 1'b0);
      if (!ir && !lr) ir = 1'b1;
      if (!pend_i) ia = {$urandom, $urandom};
      if (!pend_l) la = {$urandom, $urandom};
      d = {$urandom, $urandom};
      predict(ir, lr, w);
      run_txn(ir, lr, ia, la, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), d, w);
      pend_i = ir && w;
      pend_l = lr && !w;
      tests_run++;
      if ((w ? obs_lsu_arr : obs_ifu_arr) !== 1 || (w ? obs_ifu_arr : obs_lsu_arr) !== 0
          || obs_addr !== (w ? la : ia)) begin
        tests_failed++;
        $display("[TB] FAIL rand_grant_%0d: got ifu_arr=%0d lsu_arr=%0d addr=%h expected lsu=%b addr=%h",
                 i, obs_ifu_arr, obs_lsu_arr, obs_addr, w, (w ? la : ia));
      end
      tests_run++;
      if ((w ? obs_lsu_data : obs_ifu_data) !== d || (w ? obs_ifu_rv : obs_lsu_rv) !== 0
          || obs_rready_stall !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL rand_data_%0d: got %h stall_ready=%b expected %h/0",
                 i, (w ? obs_lsu_data : obs_ifu_data), obs_rready_stall, d);
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_ifu_alone();
    test_tie();
    test_ar_delay();
    test_r_stall();
    test_reset_mid_data();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
